video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, h front porch pixels
- H_SYNC, 96, h sync pixels
- H_BACK, 48, h back porch pixels
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, v front porch lines
- V_SYNC, 2, v sync lines
- V_BACK, 33, v back porch lines
- HS_POL, 0, active level of hs
- VS_POL, 0, active level of vs
- LEAD, 2, fetch look-ahead in clocks, range 1..H_ACTIVE-1
- XW, 11, x width; YW, 10, y width
REQ-002 Ports, one per line: name, direction, width, meaning.
- vga_clk, in, 1, pixel clock; all logic on rising edge
- reset, in, 1, asynchronous, active-high
- en, in, 1, run enable
- irq_line, in, YW, line number for line_irq
- hs, out, 1, horizontal sync
- vs, out, 1, vertical sync
- de, out, 1, active-video data enable
- x, out, XW, active pixel column
- y, out, YW, active line
- sol, out, 1, start-of-active-line pulse
- sof, out, 1, start-of-frame pulse
- line_irq, out, 1, line-match pulse
- frame_cnt, out, 16, frames started
- fetch_valid, out, 1, look-ahead data enable
- fetch_x, out, XW, look-ahead column
- fetch_y, out, YW, look-ahead line

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise; h_cnt counts 0..H_TOTAL-1 and wraps; v_cnt increments on h wrap and wraps at V_TOTAL-1.
REQ-004 Line order: active [0,H_ACTIVE), front, sync [H_ACTIVE+H_FRONT, +H_SYNC), back; frame order identical in lines.
REQ-005 All outputs are registered; outputs in cycle n reflect the counter state of cycle n-1.
REQ-006 hs = HS_POL in h sync, otherwise ~HS_POL; vs = VS_POL on all cycles of v sync lines, otherwise ~VS_POL.
REQ-007 de = 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE; x = h_cnt and y = v_cnt when de, otherwise both 0.
REQ-008 sol = 1 for one cycle when h_cnt = 0 and v_cnt < V_ACTIVE; sof = 1 for one cycle when h_cnt = 0 and v_cnt = 0.
REQ-009 frame_cnt increments, mod 2^16, in the same cycle sof asserts.
REQ-010 line_irq = 1 for one cycle when h_cnt = H_ACTIVE and v_cnt = irq_line; never fires if irq_line >= V_TOTAL.
REQ-011 fetch_valid, fetch_x and fetch_y equal the values de, x and y take LEAD cycles later, including across line and frame wrap. The look-ahead position (h,v) + LEAD wraps modulo H_TOTAL, carrying into v modulo V_TOTAL.
REQ-012 en low: counters are held at (0,0); hs and vs are inactive; de, sol, sof, line_irq and fetch_valid are 0; x, y, fetch_x and fetch_y are 0; frame_cnt holds.
REQ-013 Deassertion of en mid-frame takes effect on the next edge (abort; no line completion). Reassertion restarts at (0,0), so sof and sol assert on the first output cycle.
REQ-014 After a restart the fetch look-ahead starts at position LEAD, so REQ-011 holds from the first enabled cycle.

Reset
REQ-015 While reset is high: counters are (0,0); frame_cnt = 0; hs = ~HS_POL; vs = ~VS_POL; every other output is 0. The first enabled cycle after reset behaves as an en restart (REQ-013).

Structure
REQ-016 A shared package video_timing_pkg holds the default timing constants, the derived H_TOTAL/V_TOTAL functions and the position struct {x, y}.
REQ-017 Sub-module video_pos_counter holds one wrapping h/v counter pair with a load value. It is instantiated twice: the display position (load 0) and the fetch position (load LEAD).

Verification
REQ-018 All scenarios use H = 4/1/2/1 (H_TOTAL 8), V = 3/1/1/1 (V_TOTAL 6) and LEAD = 2.
REQ-019 Reset release with en = 1 -> sof = sol = 1 in the first output cycle; de high 4 cycles with x = 0..3; hs low at line cycles 5..6.
REQ-020 Run 3 frames -> frame period 48 cycles; vs low exactly 8 cycles per frame; frame_cnt = 3.
REQ-021 HS_POL = 1, VS_POL = 1 -> sync pulses high with identical timing.
REQ-022 Compare fetch outputs with de/x/y delayed 2 cycles over 2 frames -> exact match, including the v wrap from line 5 to line 0.
REQ-023 Drop en at line 1, x = 2, then re-raise after 5 cycles -> outputs idle the cycle after the drop; sof restarts; frame_cnt increments by 1.
REQ-024 irq_line = 2 -> line_irq pulses once per frame, 4 cycles after sol of line 2. irq_line = 7 -> no pulse.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared timing defaults, derived frame totals and the pixel position payload
// used by the video timing generator and its users.
package video_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;
  localparam int unsigned DEF_LEAD     = 2;
  localparam int unsigned DEF_XW       = 11;
  localparam int unsigned DEF_YW       = 10;

  typedef struct packed {
    logic [DEF_XW-1:0] x;
    logic [DEF_YW-1:0] y;
  } pos_t;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/video_pos_counter.sv
// Wrapping horizontal/vertical position counter. While disabled it sits at its
// load position so the next enabled cycle starts from there.
module video_pos_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_TOTAL = 525,
  parameter int unsigned XW      = DEF_XW,
  parameter int unsigned YW      = DEF_YW,
  parameter int unsigned H_LOAD  = 0,
  parameter int unsigned V_LOAD  = 0
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          en_i,
  output logic [XW-1:0] h_o,
  output logic [YW-1:0] v_o
);

  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!en_i) begin
      h_d = XW'(H_LOAD);
      v_d = YW'(V_LOAD);
    end else if (h_q == XW'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == YW'(V_TOTAL - 1)) ? '0 : v_q + YW'(1);
    end else begin
      h_d = h_q + XW'(1);
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      h_q <= XW'(H_LOAD);
      v_q <= YW'(V_LOAD);
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o = h_q;
  assign v_o = v_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: syncs, data enable, pixel coordinates, frame/line
// events and a look-ahead fetch position running LEAD clocks ahead.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned LEAD     = DEF_LEAD,
  parameter int unsigned XW       = DEF_XW,
  parameter int unsigned YW       = DEF_YW
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          en,
  input  logic [YW-1:0] irq_line,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sol,
  output logic          sof,
  output logic          line_irq,
  output logic [15:0]   frame_cnt,
  output logic          fetch_valid,
  output logic [XW-1:0] fetch_x,
  output logic [YW-1:0] fetch_y
);

  localparam int unsigned H_TOTAL  = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL  = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [XW-1:0] h, fh;
  logic [YW-1:0] v, fv;

  // Display position starts at (0,0); fetch position is the same raster LEAD ahead.
  video_pos_counter #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .XW(XW), .YW(YW), .H_LOAD(0), .V_LOAD(0)
  ) u_disp_pos (
    .vga_clk(vga_clk), .reset(reset), .en_i(en), .h_o(h), .v_o(v)
  );

  video_pos_counter #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .XW(XW), .YW(YW), .H_LOAD(LEAD), .V_LOAD(0)
  ) u_fetch_pos (
    .vga_clk(vga_clk), .reset(reset), .en_i(en), .h_o(fh), .v_o(fv)
  );

  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [XW-1:0] x_q, x_d, fx_q, fx_d;
  logic [YW-1:0] y_q, y_d, fy_q, fy_d;
  logic          sol_q, sol_d, sof_q, sof_d, lirq_q, lirq_d, fv_q, fv_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic disp_act, fetch_act;

  assign disp_act  = (h < XW'(H_ACTIVE)) && (v < YW'(V_ACTIVE));
  assign fetch_act = (fh < XW'(H_ACTIVE)) && (fv < YW'(V_ACTIVE));

  // Next output values decoded from the current counter state; idle when disabled.
  always_comb begin
    hs_d        = ~HS_POL;
    vs_d        = ~VS_POL;
    de_d        = 1'b0;
    x_d         = '0;
    y_d         = '0;
    sol_d       = 1'b0;
    sof_d       = 1'b0;
    lirq_d      = 1'b0;
    fv_d        = 1'b0;
    fx_d        = '0;
    fy_d        = '0;
    frame_cnt_d = frame_cnt_q;
    if (en) begin
      if ((h >= XW'(HS_START)) && (h < XW'(HS_END))) hs_d = HS_POL;
      if ((v >= YW'(VS_START)) && (v < YW'(VS_END))) vs_d = VS_POL;
      de_d   = disp_act;
      x_d    = disp_act ? h : '0;
      y_d    = disp_act ? v : '0;
      sol_d  = (h == '0) && (v < YW'(V_ACTIVE));
      sof_d  = (h == '0) && (v == '0);
      lirq_d = (h == XW'(H_ACTIVE)) && (v == irq_line);
      fv_d   = fetch_act;
      fx_d   = fetch_act ? fh : '0;
      fy_d   = fetch_act ? fv : '0;
      if (sof_d) frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      de_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      sol_q       <= 1'b0;
      sof_q       <= 1'b0;
      lirq_q      <= 1'b0;
      fv_q        <= 1'b0;
      fx_q        <= '0;
      fy_q        <= '0;
      frame_cnt_q <= '0;
    end else begin
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sol_q       <= sol_d;
      sof_q       <= sof_d;
      lirq_q      <= lirq_d;
      fv_q        <= fv_d;
      fx_q        <= fx_d;
      fy_q        <= fy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign sol         = sol_q;
  assign sof         = sof_q;
  assign line_irq    = lirq_q;
  assign frame_cnt   = frame_cnt_q;
  assign fetch_valid = fv_q;
  assign fetch_x     = fx_q;
  assign fetch_y     = fy_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small 8x6 raster: directed scenarios plus
// random enable/irq stimulus against a linear-position reference model.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int LD = 2;
  localparam int XW = 11, YW = 10;

  logic          vga_clk = 1'b0;
  logic          reset   = 1'b1;
  logic          en      = 1'b0;
  logic [YW-1:0] irq_line = '0;

  logic          hs, vs, de, sol, sof, line_irq, fetch_valid;
  logic [XW-1:0] x, fetch_x;
  logic [YW-1:0] y, fetch_y;
  logic [15:0]   frame_cnt;

  logic          p_hs, p_vs, p_de, p_sol, p_sof, p_line_irq, p_fetch_valid;
  logic [XW-1:0] p_x, p_fetch_x;
  logic [YW-1:0] p_y, p_fetch_y;
  logic [15:0]   p_frame_cnt;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(LD), .XW(XW), .YW(YW)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .en(en), .irq_line(irq_line),
    .hs(hs), .vs(vs), .de(de), .x(x), .y(y), .sol(sol), .sof(sof),
    .line_irq(line_irq), .frame_cnt(frame_cnt), .fetch_valid(fetch_valid),
    .fetch_x(fetch_x), .fetch_y(fetch_y)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .LEAD(LD), .XW(XW), .YW(YW)
  ) dut_p (
    .vga_clk(vga_clk), .reset(reset), .en(en), .irq_line(irq_line),
    .hs(p_hs), .vs(p_vs), .de(p_de), .x(p_x), .y(p_y), .sol(p_sol), .sof(p_sof),
    .line_irq(p_line_irq), .frame_cnt(p_frame_cnt), .fetch_valid(p_fetch_valid),
    .fetch_x(p_fetch_x), .fetch_y(p_fetch_y)
  );

  always #5 vga_clk = ~vga_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: linear position within the frame plus a frame counter.
  int   m_pos = 0;
  int   m_fc  = 0;
  logic e_de, e_hs_act, e_vs_act, e_sol, e_sof, e_lirq, e_fv;
  pos_t e_pos, e_fpos;

  int         cyc = 0;
  int         sof_last = -1;
  int         vs_low = 0;
  int         lirq_n = 0;
  bit         collect = 1'b0;
  logic [31:0] fq[$];
  int         fc_before;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_exp(input logic on, input logic [YW-1:0] irq);
    int h, v, fp, fh, fv;
    h  = m_pos % HT;
    v  = m_pos / HT;
    fp = (m_pos + LD) % FT;
    fh = fp % HT;
    fv = fp / HT;
    e_de     = on && (h < HA) && (v < VA);
    e_pos.x  = e_de ? 11'(h) : '0;
    e_pos.y  = e_de ? 10'(v) : '0;
    e_hs_act = on && (h >= HA + HF) && (h < HA + HF + HS);
    e_vs_act = on && (v >= VA + VF) && (v < VA + VF + VS);
    e_sol    = on && (h == 0) && (v < VA);
    e_sof    = on && (m_pos == 0);
    e_lirq   = on && (h == HA) && (v == int'(irq));
    e_fv     = on && (fh < HA) && (fv < VA);
    e_fpos.x = e_fv ? 11'(fh) : '0;
    e_fpos.y = e_fv ? 10'(fv) : '0;
  endtask

  task automatic model_edge(input logic on, input logic [YW-1:0] irq);
    set_exp(on, irq);
    if (on && m_pos == 0) m_fc = (m_fc + 1) % 65536;
    m_pos = on ? (m_pos + 1) % FT : 0;
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_fc  = 0;
    set_exp(1'b0, '0);
  endtask

  task automatic check_outputs();
    chk("hs",          32'(hs),          32'(!e_hs_act));
    chk("vs",          32'(vs),          32'(!e_vs_act));
    chk("de",          32'(de),          32'(e_de));
    chk("x",           32'(x),           32'(e_pos.x));
    chk("y",           32'(y),           32'(e_pos.y));
    chk("sol",         32'(sol),         32'(e_sol));
    chk("sof",         32'(sof),         32'(e_sof));
    chk("line_irq",    32'(line_irq),    32'(e_lirq));
    chk("frame_cnt",   32'(frame_cnt),   32'(m_fc));
    chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
    chk("fetch_x",     32'(fetch_x),     32'(e_fpos.x));
    chk("fetch_y",     32'(fetch_y),     32'(e_fpos.y));
    chk("hs_pol1",     32'(p_hs),        32'(e_hs_act));
    chk("vs_pol1",     32'(p_vs),        32'(e_vs_act));
    chk("de_pol1",     32'(p_de),        32'(e_de));
    chk("sof_pol1",    32'(p_sof),       32'(e_sof));
  endtask

  task automatic step(input logic en_v, input logic [YW-1:0] irq_v);
    en = en_v;
    irq_line = irq_v;
    @(posedge vga_clk);
    model_edge(en_v, irq_v);
    #1;
    cyc++;
    check_outputs();
    // Fetch outputs must reproduce de/x/y LD cycles later within an enabled run.
    if (!en_v) fq.delete();
    else begin
      fq.push_back(32'({fetch_valid, fetch_x, fetch_y}));
      if (fq.size() > LD) chk("fetch_vs_de_delayed", 32'({de, x, y}), fq.pop_front());
    end
    if (collect) begin
      if (vs === 1'b0) vs_low++;
      if (line_irq === 1'b1) lirq_n++;
      if (sof === 1'b1) begin
        if (sof_last >= 0) chk("frame_period", 32'(cyc - sof_last), 32'(FT));
        sof_last = cyc;
      end
    end
  endtask

  initial begin
    // Reset held with en high: everything idle, frame_cnt zero.
    reset = 1'b1;
    en = 1'b1;
    irq_line = 10'd2;
    repeat (3) @(posedge vga_clk);
    #1;
    model_reset();
    check_outputs();
    reset = 1'b0;

    // Three full frames from reset release.
    collect = 1'b1;
    for (int i = 0; i < 3 * FT; i++) step(1'b1, 10'd2);
    collect = 1'b0;
    chk("frame_cnt_after_3", 32'(frame_cnt), 32'd3);
    chk("vs_low_cycles_3_frames", 32'(vs_low), 32'(3 * VS * HT));
    chk("line_irq_count_3_frames", 32'(lirq_n), 32'd3);

    // Abort at line 1, x = 2, idle for 5 cycles, then restart.
    for (int i = 0; i < HT + 2; i++) step(1'b1, 10'd2);
    fc_before = int'(frame_cnt);
    for (int i = 0; i < 5; i++) step(1'b0, 10'd2);
    step(1'b1, 10'd2);
    chk("sof_on_restart", 32'(sof), 32'd1);
    chk("frame_cnt_restart_inc", 32'(frame_cnt), 32'((fc_before + 1) % 65536));
    for (int i = 0; i < 2 * FT; i++) step(1'b1, 10'd2);

    // Out-of-range irq line never fires.
    lirq_n = 0;
    sof_last = -1;
    collect = 1'b1;
    for (int i = 0; i < FT; i++) step(1'b1, 10'd7);
    collect = 1'b0;
    chk("line_irq_out_of_range", 32'(lirq_n), 32'd0);

    // Random enable drops and irq lines.
    for (int i = 0; i < 400; i++)
      step(logic'($urandom_range(0, 7) != 0), YW'($urandom_range(0, 7)));

    // Asynchronous reset mid-cycle.
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    fq.delete();
    check_outputs();
    @(posedge vga_clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 60; i++) step(1'b1, YW'($urandom_range(0, 5)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
